// File: rtl/uart_word_tx_pkg.sv
// uart_word_tx_pkg: shared UART state encoding, default timing constants and width helper
package uart_word_tx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam int DEF_DATA_BITS      = 8;
  localparam int DEF_SB_TICK        = 16;
  localparam int DEF_OVERSAMPLE     = 16;
  localparam int DEF_BYTES_PER_WORD = 4;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_word_tx_byte.sv
// uart_word_tx_byte: 8N1 serializer timed by an oversampling baud tick, chainable with no idle gap
//  clk, reset       system clock, synchronous active-high reset
//  i_tick           baud tick (OVERSAMPLE per start/data bit, SB_TICK for stop)
//  i_din            byte to send, sampled with i_tx_start
//  i_tx_start       start request, honoured in IDLE or on the final stop-bit tick
//  o_tx             registered serial line, idle high
//  o_tx_done_tick   registered pulse after each stop bit
//  o_idle           decoded IDLE state
//  o_frame_end      combinational: this cycle's tick ends the stop bit
module uart_word_tx_byte
  import uart_word_tx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int SB_TICK    = DEF_SB_TICK,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_din,
  input  logic                 i_tx_start,
  output logic                 o_tx,
  output logic                 o_tx_done_tick,
  output logic                 o_idle,
  output logic                 o_frame_end
);
  localparam int CW = cnt_width(OVERSAMPLE > SB_TICK ? OVERSAMPLE : SB_TICK);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] OS_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  state_t               r_state;
  logic [CW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_byte;
  logic                 r_tx;
  logic                 r_done;
  logic                 w_os_end;
  logic                 w_bit_last;
  logic [CW-1:0]        w_tick_inc;
  assign w_os_end       = i_tick & (r_tick_cnt == OS_LAST);
  assign w_bit_last     = r_bit_cnt == BIT_LAST;
  assign w_tick_inc     = r_tick_cnt + CW'(1);
  assign o_frame_end    = (r_state == S_STOP) & i_tick & (r_tick_cnt == SB_LAST);
  assign o_idle         = r_state == S_IDLE;
  assign o_tx           = r_tx;
  assign o_tx_done_tick = r_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte     <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= o_frame_end;
      case (r_state)
        S_IDLE:
          if (i_tx_start) begin
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_byte     <= i_din;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        S_START:
          if (i_tick) begin
            r_tick_cnt <= w_os_end ? '0 : w_tick_inc;
            if (w_os_end) begin
              r_state <= S_DATA;
              r_tx    <= r_byte[0];
            end
          end
        S_DATA:
          if (i_tick) begin
            r_tick_cnt <= w_os_end ? '0 : w_tick_inc;
            if (w_os_end) begin
              r_byte    <= r_byte >> 1;
              r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BW'(1);
              r_state   <= w_bit_last ? S_STOP : S_DATA;
              r_tx      <= w_bit_last | r_byte[1];
            end
          end
        S_STOP:
          if (i_tick) begin
            r_tick_cnt <= o_frame_end ? '0 : w_tick_inc;
            // chaining straight into the next start bit keeps frames back to back
            if (o_frame_end) begin
              r_state <= i_tx_start ? S_START : S_IDLE;
              r_tx    <= ~i_tx_start;
              r_byte  <= i_tx_start ? i_din : r_byte;
            end
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: serializes 32-bit debug words as consecutive little-endian 8N1 frames
//  clk, reset       system clock, synchronous active-high reset
//  tick             baud tick from the shared baud generator
//  word_in          word to send; word_valid qualifies it
//  word_ready       high only while idle; transfer on word_valid & word_ready
//  tx               registered serial line, idle high
//  tx_busy          high from acceptance until the last stop bit completes
//  byte_done_tick   pulse after every frame's stop bit
//  word_done_tick   pulse coincident with the final byte_done_tick of a word
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int SB_TICK        = DEF_SB_TICK,
  parameter int OVERSAMPLE     = DEF_OVERSAMPLE,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                tick,
  input  logic [DATA_BITS*BYTES_PER_WORD-1:0] word_in,
  input  logic                                word_valid,
  output logic                                word_ready,
  output logic                                tx,
  output logic                                tx_busy,
  output logic                                byte_done_tick,
  output logic                                word_done_tick
);
  localparam int IW = cnt_width(BYTES_PER_WORD);
  localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);
  logic [DATA_BITS*BYTES_PER_WORD-1:0] r_word_buf;
  logic [IW-1:0]                       r_byte_idx;
  logic                                r_busy;
  logic                                r_word_done;
  logic [IW-1:0]                       w_next_idx;
  logic [DATA_BITS-1:0]                w_din;
  logic                                w_idle;
  logic                                w_accept;
  logic                                w_more;
  logic                                w_frame_end;
  assign w_accept       = word_valid & w_idle;
  assign w_more         = r_busy & (r_byte_idx != LAST);
  assign w_next_idx     = r_byte_idx + IW'(1);
  // the byte presented at a frame end is the one after the byte currently on the line
  assign w_din          = w_accept ? word_in[DATA_BITS-1:0] : r_word_buf[w_next_idx*DATA_BITS +: DATA_BITS];
  assign word_ready     = w_idle;
  assign tx_busy        = r_busy;
  assign word_done_tick = r_word_done;
  uart_word_tx_byte #(
    .DATA_BITS (DATA_BITS),
    .SB_TICK   (SB_TICK),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_byte (
    .clk           (clk),
    .reset         (reset),
    .i_tick        (tick),
    .i_din         (w_din),
    .i_tx_start    (w_accept | w_more),
    .o_tx          (tx),
    .o_tx_done_tick(byte_done_tick),
    .o_idle        (w_idle),
    .o_frame_end   (w_frame_end)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_buf  <= '0;
      r_byte_idx  <= '0;
      r_busy      <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= w_frame_end & ~w_more;
      if (w_accept) begin
        r_word_buf <= word_in;
        r_byte_idx <= '0;
        r_busy     <= 1'b1;
      end else if (w_frame_end) begin
        r_byte_idx <= w_more ? w_next_idx : r_byte_idx;
        r_busy     <= w_more;
      end
    end
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: randomized bench comparing the line against a tick-count model of the framing
module tb_uart_word_tx;
  localparam int OS         = 16;
  localparam int SB         = 16;
  localparam int DB         = 8;
  localparam int BPW        = 4;
  localparam int FRAME      = (1 + DB) * OS + SB;
  localparam int WORD_TICKS = FRAME * BPW;
  logic        clk = 0, reset = 1, tick = 0, word_valid = 0;
  logic [31:0] word_in = 0;
  logic        word_ready, tx, tx_busy, byte_done_tick, word_done_tick;
  int          n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  uart_word_tx dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .word_in       (word_in),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .byte_done_tick(byte_done_tick),
    .word_done_tick(word_done_tick)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic tick_en = 0;
  int   tick_per = 16, tcnt = 0;
  always @(negedge clk) begin
    if (!tick_en) tick <= 1'b0;
    else begin
      tick <= (tcnt == 0);
      tcnt <= (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
    end
  end
  // model: a word is a run of WORD_TICKS ticks; the line level is a function of ticks elapsed
  logic        m_active = 0, m_bd = 0, m_wd = 0;
  int          m_k = 0;
  logic [31:0] m_word = 0;
  always @(posedge clk) begin
    m_bd <= 1'b0;
    m_wd <= 1'b0;
    if (reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (word_valid) begin
        m_active <= 1'b1;
        m_word   <= word_in;
        m_k      <= 0;
      end
    end else if (tick) begin
      m_k <= m_k + 1;
      if ((m_k + 1) % FRAME == 0) m_bd <= 1'b1;
      if (m_k + 1 == WORD_TICKS) begin
        m_wd     <= 1'b1;
        m_active <= 1'b0;
      end
    end
  end
  function automatic logic exp_tx();
    int          p = m_k % FRAME;
    logic [31:0] w = m_word >> (DB * (m_k / FRAME));
    if (!m_active) return 1'b1;
    if (p < OS) return 1'b0;
    if (p < (1 + DB) * OS) return w[p / OS - 1];
    return 1'b1;
  endfunction
  logic mon_en = 0;
  int   n_bd = 0, n_wd = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("tx", tx, exp_tx());
      check("word_ready", word_ready, !m_active);
      check("tx_busy", tx_busy, m_active);
      check("byte_done_tick", byte_done_tick, m_bd);
      check("word_done_tick", word_done_tick, m_wd);
      n_bd <= n_bd + int'(byte_done_tick);
      n_wd <= n_wd + int'(word_done_tick);
    end
  end
  task automatic wait_ready(input int bound);
    int i = 0;
    while (!word_ready && i < bound) begin
      @(negedge clk);
      i++;
    end
    check("ready_timeout", word_ready, 1);
  endtask
  task automatic wait_idle(input int bound);
    wait_ready(bound);
    @(negedge clk);
  endtask
  task automatic send_word(input logic [31:0] w);
    wait_ready(20000);
    word_in    = w;
    word_valid = 1;
    @(negedge clk);
    word_valid = 0;
  endtask
  task automatic wait_k(input int target, input int bound);
    int i = 0;
    while (m_k != target && i < bound) begin
      @(negedge clk);
      i++;
    end
    check("k_timeout", m_k, target);
  endtask
  int bd0, wd0;
  initial begin
    reset = 1;
    repeat (4) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", word_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_bd", byte_done_tick, 0);
    check("rst_wd", word_done_tick, 0);
    reset   = 0;
    mon_en  = 1;
    tick_en = 1;
    // single word, tick every 16 clocks
    bd0 = n_bd; wd0 = n_wd;
    send_word(32'h0000_04FC);
    wait_idle(12000);
    check("t2_bytes", n_bd - bd0, 4);
    check("t2_words", n_wd - wd0, 1);
    // back to back with word_valid held high
    tick_per = 4;
    bd0 = n_bd; wd0 = n_wd;
    word_in = 32'h0000_0001;
    word_valid = 1;
    @(negedge clk);
    word_in = 32'hDEAD_BEEF;
    wait_ready(8000);
    @(negedge clk);
    word_valid = 0;
    wait_idle(8000);
    repeat (100) @(negedge clk);
    check("t3_bytes", n_bd - bd0, 8);
    check("t3_words", n_wd - wd0, 2);
    // valid and data churn while busy
    tick_per = 2;
    bd0 = n_bd;
    send_word($urandom);
    repeat (10) begin
      word_valid = 1'($urandom);
      word_in    = $urandom;
      repeat ($urandom_range(10, 100)) @(negedge clk);
    end
    word_valid = 0;
    wait_idle(4000);
    check("t4_bytes", n_bd - bd0, 4);
    // reset during data bit 3 of byte 1
    bd0 = n_bd; wd0 = n_wd;
    send_word($urandom);
    wait_k(FRAME + OS * 4 + 6, 4000);
    reset = 1;
    @(negedge clk);
    check("t5_tx", tx, 1);
    check("t5_ready", word_ready, 1);
    reset = 0;
    repeat (50) @(negedge clk);
    check("t5_bytes", n_bd - bd0, 1);
    check("t5_words", n_wd - wd0, 0);
    send_word($urandom);
    wait_idle(4000);
    // tick stalled during the start bit
    tick_per = 3;
    send_word($urandom);
    wait_k(5, 100);
    tick_en = 0;
    repeat (200) @(negedge clk);
    check("t6_tx", tx, 0);
    check("t6_busy", tx_busy, 1);
    tick_en = 1;
    wait_idle(4000);
    // random words and tick rates
    repeat (4) begin
      tick_per = $urandom_range(1, 3);
      bd0 = n_bd;
      send_word($urandom);
      wait_idle(4000);
      check("rand_bytes", n_bd - bd0, 4);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
